julia_frame_scanout: RTL and testbench
======================================

Name: julia_frame_scanout

Overview:
- Consumer end of the fractal pixel stream: accepts (x, y, intensity) pixel writes from the fractal calculator and stores them in an on-chip frame buffer.
- Independently scans the buffer out with 640x480 VGA timing (800x525 total), producing sync, blank and 8-bit RGB.
- Sits between the fractal calculator and the VGA DAC pins.

Parameters:
- IMG_W, 640, visible width in pixels and frame buffer row length
- IMG_H, 480, visible height in lines
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 525, lines per frame
- PIX_DIV, 2, CLK cycles per pixel; pix_en pulses once every PIX_DIV cycles

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- clear_req  in  1  single-cycle request to re-clear the frame buffer
- wr_valid  in  1  pixel write strobe
- wr_x  in  10  write column
- wr_y  in  10  write row
- wr_intensity  in  8  escape intensity, nominal 0..100
- wr_ready  out  1  buffer accepts writes
- wr_oob  out  1  sticky: a write had wr_x>=IMG_W or wr_y>=IMG_H
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank_n  out  1  high in the visible region
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- frame_start  out  1  one-CLK pulse when the scan counters wrap to (0,0)

Behaviour:
- Reset and clock: single clock domain. RESET is asynchronous, active-high; every register uses it.
- Reset values: wr_ready=0, wr_oob=0, vga_hs=1, vga_vs=1, vga_blank_n=0, RGB=0, frame_start=0, hcnt=vcnt=0, FSM=CLEAR, clear address=0.
- FSM state CLEAR: writes 0 to one address per CLK, from 0 to IMG_W*IMG_H-1. wr_ready=0; incoming writes are ignored. After the last address, go to RUN.
- FSM state RUN: wr_ready=1.
  - A write is accepted when wr_valid & wr_ready.
  - If in range: address = wr_y*IMG_W + wr_x; data = min(wr_intensity,100), 7 bits.
  - If out of range: the write is dropped and wr_oob is set (sticky until RESET).
- clear_req in RUN: go to CLEAR at address 0. A write presented in that same cycle is dropped.
- clear_req during CLEAR: ignored.
- RESET mid-clear: the clear restarts from address 0.
- Scan counters advance only on pix_en.
  - hcnt wraps 799->0; at that wrap vcnt increments, wrapping 524->0.
  - frame_start pulses in the CLK cycle in which both counters become 0.
- Horizontal timing: visible hcnt 0..639; sync low for 656..751.
- Vertical timing: visible vcnt 0..479; sync low for 490..491.
- Blanking: vga_blank_n = hcnt<640 && vcnt<480.
- Read pipeline:
  - Stage 1: the read address is registered from the counters.
  - Stage 2: the RAM output (registered) is colour-mapped and registered to the pins.
  - hs, vs and blank_n are delayed by the same 2 CLK, so all pin outputs align.
  - Scan-out runs in both CLEAR and RUN; reading during CLEAR shows partially cleared data.
- Colour map:
  - s = (v*653)>>8 (v=0 gives 0, v=50 gives 127, v=100 gives 255).
  - Default: r=g=b=s.
  - When blanked, RGB=0.
- Same-address read and write in the same cycle: the read returns the old data.

Optional Feature:
- Macro COLOR_MAP_EN.
- Defined: r=s, g=s>>1, b=255-s in the visible region; blanked pixels are still 0.
- Undefined: greyscale r=g=b=s.

Decomposition:
- Package julia_vga_pkg holds:
  - the timing constants (H_VIS=640, H_SYNC_START=656, H_SYNC_END=751, V_VIS=480, V_SYNC_START=490, V_SYNC_END=491);
  - INTENSITY_MAX=100 and the scale constant 653;
  - the FSM enum typedef {CLEAR, RUN}.
- One sub-module, fb_dpram: simple dual-port RAM with one write port, one registered read port and old-data read-during-write, parameterised for depth and width.

Test Plan:
- Reset, then wait for the clear to finish: wr_ready goes high exactly 307200 CLK after RESET deasserts; all visible pixels read RGB=0.
- Write (x=10, y=20, int=100), then scan: vga_r/g/b=255 at the visible pixel hcnt=10, vcnt=20, aligned with vga_blank_n=1; neighbouring pixels are 0.
- Write int=200 at (0,0): it is clamped, so the output is 255. Write int=50 at (1,0): the output is 127.
- Write (x=640, y=0) and (x=0, y=480): both are dropped, wr_oob=1 and stays set; the frame buffer is unchanged.
- Timing: vga_hs is low for 96 pixel periods per 800; vga_vs is low for 2 lines per 525; frame_start occurs once per 800*525*PIX_DIV CLK.
- clear_req while the buffer is populated: wr_ready drops the next cycle, a write with wr_valid=1 during CLEAR is ignored, and after the clear the pixels read 0. An asynchronous RESET asserted mid-clear returns all outputs to their reset values immediately.

Source files
------------

// File: rtl/julia_vga_pkg.sv
// Shared VGA timing constants, intensity scaling and frame-buffer FSM states
// for the Julia fractal scan-out path.
package julia_vga_pkg;

   localparam int unsigned H_VIS         = 640;
   localparam int unsigned H_SYNC_START  = 656;
   localparam int unsigned H_SYNC_END    = 751;
   localparam int unsigned H_TOTAL_STD   = 800;
   localparam int unsigned V_VIS         = 480;
   localparam int unsigned V_SYNC_START  = 490;
   localparam int unsigned V_SYNC_END    = 491;
   localparam int unsigned V_TOTAL_STD   = 525;
   localparam int unsigned PIX_DIV_STD   = 2;

   localparam int unsigned INTENSITY_MAX = 100;
   localparam int unsigned SCALE_MUL     = 653;

   typedef enum logic {
      CLEAR,
      RUN
   } fb_state_t;

   // Maps stored intensity 0..100 onto 0..255.
   function automatic logic [7:0] scale_intensity(input logic [6:0] v);
      return 8'((16'(v) * 16'(SCALE_MUL)) >> 8);
   endfunction

endpackage

// File: rtl/julia_frame_scanout_fb_dpram.sv
// Simple dual-port frame-buffer RAM: one write port, one registered read port
// that returns the old contents on a same-address read/write collision.
module fb_dpram #(
   parameter int unsigned DEPTH = 307200,
   parameter int unsigned WIDTH = 7,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) rdata <= '0;
      else       rdata <= mem[raddr];
   end

endmodule

// File: rtl/julia_frame_scanout.sv
// Fractal pixel sink: clears and fills the frame buffer, then scans it out with VGA timing.
// Build option: define COLOR_MAP_EN for a false-colour palette instead of greyscale.
module julia_frame_scanout
   import julia_vga_pkg::*;
#(
   parameter int unsigned IMG_W        = H_VIS,
   parameter int unsigned IMG_H        = V_VIS,
   parameter int unsigned H_TOTAL      = H_TOTAL_STD,
   parameter int unsigned V_TOTAL      = V_TOTAL_STD,
   parameter int unsigned PIX_DIV      = PIX_DIV_STD,
   parameter int unsigned H_SYNC_BEG   = H_SYNC_START,
   parameter int unsigned H_SYNC_FIN   = H_SYNC_END,
   parameter int unsigned V_SYNC_BEG   = V_SYNC_START,
   parameter int unsigned V_SYNC_FIN   = V_SYNC_END
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       clear_req,
   input  logic       wr_valid,
   input  logic [9:0] wr_x,
   input  logic [9:0] wr_y,
   input  logic [7:0] wr_intensity,
   output logic       wr_ready,
   output logic       wr_oob,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       frame_start
);

   localparam int unsigned DEPTH = IMG_W * IMG_H;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned HW    = $clog2(H_TOTAL);
   localparam int unsigned VW    = $clog2(V_TOTAL);
   localparam int unsigned DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
   localparam logic [9:0]    WX_LIM    = 10'(IMG_W);
   localparam logic [9:0]    WY_LIM    = 10'(IMG_H);
   localparam logic [7:0]    INT_MAX8  = 8'(INTENSITY_MAX);
   localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_C   = HW'(IMG_W);
   localparam logic [HW-1:0] HS_BEG    = HW'(H_SYNC_BEG);
   localparam logic [HW-1:0] HS_FIN    = HW'(H_SYNC_FIN);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS_C   = VW'(IMG_H);
   localparam logic [VW-1:0] VS_BEG    = VW'(V_SYNC_BEG);
   localparam logic [VW-1:0] VS_FIN    = VW'(V_SYNC_FIN);

   fb_state_t     state, state_nx;
   logic [AW-1:0] clr_addr, clr_addr_nx;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [6:0]    ram_wdata;
   logic          oob_set;
   logic          wr_in_range;

   // Clear sweep and pixel-write acceptance.
   always_comb begin
      state_nx    = state;
      clr_addr_nx = clr_addr;
      ram_we      = 1'b0;
      ram_waddr   = clr_addr;
      ram_wdata   = '0;
      oob_set     = 1'b0;
      wr_in_range = (wr_x < WX_LIM) && (wr_y < WY_LIM);
      case (state)
         CLEAR: begin
            ram_we = 1'b1;
            if (clr_addr == ADDR_LAST) begin
               state_nx    = RUN;
               clr_addr_nx = '0;
            end else begin
               clr_addr_nx = clr_addr + AW'(1);
            end
         end
         RUN: begin
            if (clear_req) begin
               state_nx    = CLEAR;
               clr_addr_nx = '0;
            end else if (wr_valid && wr_ready) begin
               if (wr_in_range) begin
                  ram_we    = 1'b1;
                  ram_waddr = AW'(wr_y) * AW'(IMG_W) + AW'(wr_x);
                  ram_wdata = (wr_intensity > INT_MAX8) ? 7'(INTENSITY_MAX) : wr_intensity[6:0];
               end else begin
                  oob_set = 1'b1;
               end
            end
         end
         default: state_nx = CLEAR;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= CLEAR;
         clr_addr <= '0;
         wr_ready <= 1'b0;
         wr_oob   <= 1'b0;
      end else begin
         state    <= state_nx;
         clr_addr <= clr_addr_nx;
         wr_ready <= (state_nx == RUN);
         wr_oob   <= wr_oob | oob_set;
      end
   end

   logic [DW-1:0] div;
   logic          pix_en;
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;

   assign pix_en = (div == DIV_LAST);

   // Pixel divider and raster counters.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         div         <= '0;
         hcnt        <= '0;
         vcnt        <= '0;
         frame_start <= 1'b0;
      end else begin
         div         <= pix_en ? '0 : div + DW'(1);
         frame_start <= pix_en && (hcnt == H_LAST) && (vcnt == V_LAST);
         if (pix_en) begin
            if (hcnt == H_LAST) begin
               hcnt <= '0;
               vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
            end else begin
               hcnt <= hcnt + HW'(1);
            end
         end
      end
   end

   logic          vis, hs_n, vs_n;
   logic [AW-1:0] raddr;
   logic [6:0]    ram_rdata;

   assign vis   = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
   assign hs_n  = !((hcnt >= HS_BEG) && (hcnt <= HS_FIN));
   assign vs_n  = !((vcnt >= VS_BEG) && (vcnt <= VS_FIN));
   assign raddr = vis ? (AW'(vcnt) * AW'(IMG_W) + AW'(hcnt)) : '0;

   fb_dpram #(
      .DEPTH (DEPTH),
      .WIDTH (7)
   ) u_fb (
      .CLK   (CLK),
      .RESET (RESET),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (raddr),
      .rdata (ram_rdata)
   );

   logic       hs_d1, vs_d1, bl_d1;
   logic [7:0] s, r_c, g_c, b_c;

   assign s = scale_intensity(ram_rdata);

   always_comb begin
      r_c = s;
      g_c = s;
      b_c = s;
`ifdef COLOR_MAP_EN
      g_c = s >> 1;
      b_c = 8'hFF - s;
`endif
   end

   // Syncs ride alongside the RAM read so every pin changes on the same edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hs_d1       <= 1'b1;
         vs_d1       <= 1'b1;
         bl_d1       <= 1'b0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
      end else begin
         hs_d1       <= hs_n;
         vs_d1       <= vs_n;
         bl_d1       <= vis;
         vga_hs      <= hs_d1;
         vga_vs      <= vs_d1;
         vga_blank_n <= bl_d1;
         vga_r       <= bl_d1 ? r_c : 8'h00;
         vga_g       <= bl_d1 ? g_c : 8'h00;
         vga_b       <= bl_d1 ? b_c : 8'h00;
      end
   end

endmodule

// File: tb/tb_julia_frame_scanout.sv
// Scoreboard bench for julia_frame_scanout on a reduced 32x24 raster (40x30 total)
// so full clears and frames fit in a short run.
module tb_julia_frame_scanout;

   localparam int TW = 32, TH = 24, THT = 40, TVT = 30, TDIV = 2;
   localparam int HSS = 34, HSE = 37, VSS = 26, VSE = 27;
   localparam int CLEAR_CYC    = 768;
   localparam int FRAME_CYC    = 2400;
   localparam int HS_LOW_FRAME = 240;
   localparam int VS_LOW_FRAME = 160;
   localparam int HS_PULSE     = 8;

   logic       CLK, RESET, clear_req, wr_valid;
   logic [9:0] wr_x, wr_y;
   logic [7:0] wr_intensity;
   logic       wr_ready, wr_oob, vga_hs, vga_vs, vga_blank_n, frame_start;
   logic [7:0] vga_r, vga_g, vga_b;

   julia_frame_scanout #(
      .IMG_W(TW), .IMG_H(TH), .H_TOTAL(THT), .V_TOTAL(TVT), .PIX_DIV(TDIV),
      .H_SYNC_BEG(HSS), .H_SYNC_FIN(HSE), .V_SYNC_BEG(VSS), .V_SYNC_FIN(VSE)
   ) dut (
      .CLK(CLK), .RESET(RESET), .clear_req(clear_req), .wr_valid(wr_valid),
      .wr_x(wr_x), .wr_y(wr_y), .wr_intensity(wr_intensity),
      .wr_ready(wr_ready), .wr_oob(wr_oob), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start)
   );

   typedef struct { string name; int act; int exp; } chk_t;
   typedef struct { int x; int y; logic [23:0] rgb; } pix_t;

   chk_t       chk_q[$];
   pix_t       pix_q[$];
   logic [7:0] model [TW*TH];
   bit         mon_en;
   int         n_cmp, n_err;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic void push_chk(input string name, input int act, input int exp);
      chk_t c;
      c.name = name; c.act = act; c.exp = exp;
      chk_q.push_back(c);
   endfunction

   function automatic logic [23:0] exp_rgb(input logic [7:0] sv);
      logic [7:0] gg, bb;
      gg = sv; bb = sv;
`ifdef COLOR_MAP_EN
      gg = sv >> 1;
      bb = 8'hFF - sv;
`endif
      return {sv, gg, bb};
   endfunction

   // Monitor: the only process that compares and counts.
   initial begin
      chk_t        c;
      pix_t        p;
      logic [23:0] rgb;
      n_cmp = 0;
      n_err = 0;
      forever begin
         @(negedge CLK);
         while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_cmp++;
            if (c.act != c.exp) begin
               n_err++;
               $display("FAIL %s: got %0d expected %0d", c.name, c.act, c.exp);
            end
         end
         if (mon_en) begin
            rgb = {vga_r, vga_g, vga_b};
            n_cmp++;
            if (vga_blank_n) begin
               if (pix_q.size() == 0) begin
                  n_err++;
                  $display("FAIL pix_extra: got %06h expected no visible pixel", rgb);
               end else begin
                  p = pix_q.pop_front();
                  if (rgb !== p.rgb) begin
                     n_err++;
                     $display("FAIL pix x=%0d y=%0d: got %06h expected %06h", p.x, p.y, rgb, p.rgb);
                  end
               end
            end else if (rgb !== 24'h0) begin
               n_err++;
               $display("FAIL blank_rgb: got %06h expected 000000", rgb);
            end
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      push_chk({tag, "_wr_ready"}, int'(wr_ready), 0);
      push_chk({tag, "_wr_oob"}, int'(wr_oob), 0);
      push_chk({tag, "_hs"}, int'(vga_hs), 1);
      push_chk({tag, "_vs"}, int'(vga_vs), 1);
      push_chk({tag, "_blank_n"}, int'(vga_blank_n), 0);
      push_chk({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
      push_chk({tag, "_frame_start"}, int'(frame_start), 0);
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (n < 2 * CLEAR_CYC) begin
         @(posedge CLK); #1;
         n++;
         if (wr_ready) break;
      end
      push_chk(name, n, CLEAR_CYC);
   endtask

   task automatic write_px(input int x, input int y, input int v);
      @(negedge CLK);
      wr_x = 10'(x); wr_y = 10'(y); wr_intensity = 8'(v); wr_valid = 1'b1;
      @(negedge CLK);
      wr_valid = 1'b0;
   endtask

   task automatic wait_frame(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 3 * FRAME_CYC; i++) begin
         @(negedge CLK);
         if (frame_start) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic scan_frame(input string name);
      bit   seen;
      pix_t p;
      wait_frame(seen);
      if (!seen) begin
         push_chk({name, "_frame_start_seen"}, 0, 1);
         return;
      end
      for (int y = 0; y < TH; y++)
         for (int x = 0; x < TW; x++) begin
            p.x = x; p.y = y; p.rgb = exp_rgb(model[y*TW + x]);
            repeat (TDIV) pix_q.push_back(p);
         end
      mon_en = 1'b1;
      for (int i = 0; i < 2 * FRAME_CYC && pix_q.size() > 0; i++) @(negedge CLK);
      mon_en = 1'b0;
      push_chk({name, "_pixels_left"}, pix_q.size(), 0);
      pix_q.delete();
   endtask

   task automatic measure_timing();
      bit seen;
      int cyc, hs_lo, vs_lo, run, pulse;
      wait_frame(seen);
      if (!seen) begin
         push_chk("timing_frame_start_seen", 0, 1);
         return;
      end
      cyc = 0; hs_lo = 0; vs_lo = 0; run = 0; pulse = 0;
      while (cyc < 2 * FRAME_CYC) begin
         @(negedge CLK);
         cyc++;
         if (!vga_hs) begin
            hs_lo++;
            run++;
         end else begin
            if (run > 0 && pulse == 0) pulse = run;
            run = 0;
         end
         if (!vga_vs) vs_lo++;
         if (frame_start) break;
      end
      push_chk("frame_period", cyc, FRAME_CYC);
      push_chk("hs_low_per_frame", hs_lo, HS_LOW_FRAME);
      push_chk("hs_pulse_width", pulse, HS_PULSE);
      push_chk("vs_low_per_frame", vs_lo, VS_LOW_FRAME);
   endtask

   initial begin
      RESET = 1'b1; clear_req = 1'b0; wr_valid = 1'b0;
      wr_x = '0; wr_y = '0; wr_intensity = '0; mon_en = 1'b0;
      for (int i = 0; i < TW*TH; i++) model[i] = 8'h00;
      #3;
      check_reset_vals("por");
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      wait_ready("clear_after_reset");
      scan_frame("cleared");

      write_px(10, 20, 100); model[20*TW + 10] = 8'd255;
      write_px(0, 0, 200);   model[0]          = 8'd255;
      write_px(1, 0, 50);    model[1]          = 8'd127;
      scan_frame("written");

      write_px(32, 0, 100);
      write_px(0, 24, 100);
      push_chk("wr_oob_set", int'(wr_oob), 1);
      scan_frame("after_oob");
      push_chk("wr_oob_sticky", int'(wr_oob), 1);

      measure_timing();

      @(negedge CLK);
      clear_req = 1'b1; wr_valid = 1'b1; wr_x = 10'd5; wr_y = 10'd5; wr_intensity = 8'd100;
      @(negedge CLK);
      clear_req = 1'b0; wr_x = 10'd6; wr_y = 10'd6;
      push_chk("ready_drop", int'(wr_ready), 0);
      wait_ready("clear_req_cycles");
      wr_valid = 1'b0;
      for (int i = 0; i < TW*TH; i++) model[i] = 8'h00;
      scan_frame("recleared");
      push_chk("wr_oob_after_clear", int'(wr_oob), 1);

      @(negedge CLK); clear_req = 1'b1;
      @(negedge CLK); clear_req = 1'b0;
      repeat (100) @(negedge CLK);
      #2 RESET = 1'b1;
      #1 check_reset_vals("midclr");
      @(negedge CLK); RESET = 1'b0;
      wait_ready("clear_restart");
      write_px(3, 2, 50); model[2*TW + 3] = 8'd127;
      scan_frame("after_restart");

      repeat (3) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
